pipeline_ctrl: RTL and testbench

Central hazard and sequencing controller for the 5-stage core (IF, ID, EX, MEM, WB). It drives the stall/flush inputs of the IF/ID, ID/EX and EX/MEM pipeline registers. It resolves load-use hazards, EX redirects, multi-cycle mul/div occupancy, memory wait states and trap drains, and it keeps a saturating stall-cycle counter. Hazard outputs are combinational from registered state plus current-cycle stage inputs, so every pipeline register sees them in the same cycle.

---
 rtl/pipeline_ctrl_pkg.sv | 14 +
 rtl/pipeline_ctrl_hazard_detect.sv | 27 ++
 rtl/pipeline_ctrl.sv | 144 ++++++++++++++
 tb/tb_pipeline_ctrl.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline hazard/sequencing controller.
// Holds the controller state encoding and the GPR address width.
package pipeline_ctrl_pkg;

  localparam int REG_BUS = 5;

  typedef enum logic [1:0] {
    PCTRL_RUN        = 2'd0,
    PCTRL_MD_WAIT    = 2'd1,
    PCTRL_MEM_WAIT   = 2'd2,
    PCTRL_TRAP_DRAIN = 2'd3
  } pctrl_state_e;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use comparator: a load in EX whose destination feeds a used ID source.
// x0 is never a real dependency, so a zero destination never matches.
module hazard_detect
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_W = REG_BUS
) (
  input  logic             id_valid,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic [REG_W-1:0] ex_gprs_waddr,
  output logic             load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = id_rs1_used & (id_rs1 == ex_gprs_waddr);
  assign rs2_hit  = id_rs2_used & (id_rs2 == ex_gprs_waddr);
  assign load_use = ex_valid & ex_is_load & (ex_gprs_waddr != '0) & id_valid
                  & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Central hazard/sequencing controller for the 5-stage core: drives the
// stall/flush controls of IF/ID, ID/EX and EX/MEM and counts stall cycles.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_W        = REG_BUS,
  parameter int DRAIN_CYCLES = 2,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_rs1_used,
  input  logic             id_rs2_used,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             ex_valid,
  input  logic             ex_is_load,
  input  logic [REG_W-1:0] ex_gprs_waddr,
  input  logic             ex_redirect,
  input  logic             ex_muldiv_start,
  input  logic             ex_muldiv_done,
  input  logic             mem_req,
  input  logic             mem_ready,
  input  logic             trap_req,
  output logic             if_id_stall,
  output logic             if_id_flush,
  output logic             id_ex_stall,
  output logic             id_ex_flush,
  output logic             ex_mem_stall,
  output logic             ex_mem_flush,
  output logic             trap_redirect,
  output logic             trap_ack,
  output logic             muldiv_kill,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  pctrl_state_e       state, next_state;
  logic [DRAIN_W-1:0] drain_cnt, next_drain;
  logic               load_use;
  logic               mem_wait;
  logic               enter_trap;

  hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
    .id_valid      (id_valid),
    .id_rs1_used   (id_rs1_used),
    .id_rs2_used   (id_rs2_used),
    .id_rs1        (id_rs1),
    .id_rs2        (id_rs2),
    .ex_valid      (ex_valid),
    .ex_is_load    (ex_is_load),
    .ex_gprs_waddr (ex_gprs_waddr),
    .load_use      (load_use)
  );

  // Once in MEM_WAIT the request is already accepted; only ready ends the wait.
  assign mem_wait = (state == PCTRL_MEM_WAIT) ? !mem_ready : (mem_req & !mem_ready);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    next_state   = state;
    next_drain   = drain_cnt;
    enter_trap   = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    ex_mem_flush = 1'b0;
    trap_ack     = 1'b0;

    if (state == PCTRL_TRAP_DRAIN) begin
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      if (drain_cnt == '0) begin
        trap_ack   = 1'b1;
        next_state = PCTRL_RUN;
      end else begin
        next_drain = drain_cnt - DRAIN_W'(1);
      end
    end else if (trap_req) begin
      enter_trap = 1'b1;
      next_state = PCTRL_TRAP_DRAIN;
      next_drain = DRAIN_W'(DRAIN_CYCLES - 1);
    end else if (state == PCTRL_MD_WAIT && !ex_muldiv_done) begin
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = mem_wait;
      ex_mem_flush = !mem_wait;
    end else if (mem_wait) begin
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
      next_state   = PCTRL_MEM_WAIT;
    end else if (ex_valid & ex_muldiv_start & !ex_muldiv_done) begin
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_flush = 1'b1;
      next_state   = PCTRL_MD_WAIT;
    end else begin
      // First unstalled cycle: a redirect held in EX wins over load-use.
      next_state = PCTRL_RUN;
      if (ex_redirect) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end
    end

    if (!rst) begin
      if_id_stall  = 1'b0;
      id_ex_stall  = 1'b0;
      ex_mem_stall = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
      trap_ack     = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= PCTRL_RUN;
      drain_cnt     <= '0;
      stall_cycles  <= '0;
      trap_redirect <= 1'b0;
      muldiv_kill   <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state         <= next_state;
      drain_cnt     <= next_drain;
      trap_redirect <= enter_trap;
      muldiv_kill   <= enter_trap & (state == PCTRL_MD_WAIT);
      if (if_id_stall && stall_cycles != '1)
        stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Self-checking bench for pipeline_ctrl: directed scenarios plus random traffic,
// with expectations queued by a reference model and compared by a monitor.
module tb_pipeline_ctrl;

  localparam int REG_W        = 5;
  localparam int DRAIN_CYCLES = 2;
  localparam int CNT_W        = 4;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  typedef struct packed {
    bit         id_valid;
    bit         rs1_used;
    bit         rs2_used;
    logic [4:0] rs1;
    logic [4:0] rs2;
    bit         ex_valid;
    bit         ex_is_load;
    logic [4:0] waddr;
    bit         redirect;
    bit         md_start;
    bit         md_done;
    bit         mem_req;
    bit         mem_ready;
    bit         trap_req;
  } stim_t;

  // ctl = {if_id_stall, if_id_flush, id_ex_stall, id_ex_flush,
  //        ex_mem_stall, ex_mem_flush, trap_redirect, trap_ack, muldiv_kill}
  typedef struct packed {
    logic [8:0]       ctl;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  logic             clk, rst;
  logic             id_valid, id_rs1_used, id_rs2_used;
  logic [REG_W-1:0] id_rs1, id_rs2, ex_gprs_waddr;
  logic             ex_valid, ex_is_load, ex_redirect;
  logic             ex_muldiv_start, ex_muldiv_done, mem_req, mem_ready, trap_req;
  logic             if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic             ex_mem_stall, ex_mem_flush, trap_redirect, trap_ack, muldiv_kill;
  logic [CNT_W-1:0] stall_cycles;

  pipeline_ctrl #(.REG_W(REG_W), .DRAIN_CYCLES(DRAIN_CYCLES), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_valid(id_valid), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .id_rs1(id_rs1), .id_rs2(id_rs2),
    .ex_valid(ex_valid), .ex_is_load(ex_is_load), .ex_gprs_waddr(ex_gprs_waddr),
    .ex_redirect(ex_redirect),
    .ex_muldiv_start(ex_muldiv_start), .ex_muldiv_done(ex_muldiv_done),
    .mem_req(mem_req), .mem_ready(mem_ready), .trap_req(trap_req),
    .if_id_stall(if_id_stall), .if_id_flush(if_id_flush),
    .id_ex_stall(id_ex_stall), .id_ex_flush(id_ex_flush),
    .ex_mem_stall(ex_mem_stall), .ex_mem_flush(ex_mem_flush),
    .trap_redirect(trap_redirect), .trap_ack(trap_ack), .muldiv_kill(muldiv_kill),
    .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: what is still owed to the pipeline, in plain terms.
  int drain_left   = 0;  // drain cycles still to run
  bit md_busy      = 0;  // a mul/div is occupying EX
  bit mem_busy     = 0;  // a bus transfer is waiting for ready
  bit kill_armed   = 0;  // trap interrupted a mul/div
  int stalls_seen  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("ctl", 32'({if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall,
                        ex_mem_flush, trap_redirect, trap_ack, muldiv_kill}), 32'(e.ctl));
      check("stall_cycles", 32'(stall_cycles), 32'(e.cnt));
    end
  end

  function automatic exp_t reset_exp();
    exp_t e;
    e.ctl = 9'b010101000;
    e.cnt = '0;
    return e;
  endfunction

  task automatic model_reset();
    drain_left  = 0;
    md_busy     = 0;
    mem_busy    = 0;
    kill_armed  = 0;
    stalls_seen = 0;
  endtask

  task automatic model_step(input stim_t s, output exp_t e);
    bit if_s = 0, if_f = 0, ie_s = 0, ie_f = 0, em_s = 0, em_f = 0;
    bit redir = 0, ack = 0, kill = 0;
    bit mw, lu;
    e.cnt = CNT_W'(stalls_seen);
    lu = s.ex_valid && s.ex_is_load && s.waddr != 0 && s.id_valid &&
         ((s.rs1_used && s.rs1 == s.waddr) || (s.rs2_used && s.rs2 == s.waddr));
    if (drain_left > 0) begin
      {if_f, ie_f, em_f} = 3'b111;
      redir = (drain_left == DRAIN_CYCLES);
      kill  = redir && kill_armed;
      ack   = (drain_left == 1);
      drain_left--;
    end else if (s.trap_req) begin
      drain_left = DRAIN_CYCLES;
      kill_armed = md_busy;
      md_busy    = 0;
      mem_busy   = 0;
    end else begin
      mw = mem_busy ? !s.mem_ready : (s.mem_req && !s.mem_ready);
      if (md_busy && !s.md_done) begin
        if_s = 1; ie_s = 1;
        if (mw) em_s = 1; else em_f = 1;
      end else if (mw) begin
        if_s = 1; ie_s = 1; em_s = 1;
        md_busy = 0; mem_busy = 1;
      end else if (s.ex_valid && s.md_start && !s.md_done) begin
        if_s = 1; ie_s = 1; em_f = 1;
        md_busy = 1; mem_busy = 0;
      end else begin
        md_busy = 0; mem_busy = 0;
        if (s.redirect) begin
          if_f = 1; ie_f = 1;
        end else if (lu) begin
          if_s = 1; ie_f = 1;
        end
      end
    end
    if (if_s && stalls_seen < CNT_MAX) stalls_seen++;
    e.ctl = {if_s, if_f, ie_s, ie_f, em_s, em_f, redir, ack, kill};
  endtask

  task automatic drive(input stim_t s);
    id_valid        = s.id_valid;
    id_rs1_used     = s.rs1_used;
    id_rs2_used     = s.rs2_used;
    id_rs1          = s.rs1;
    id_rs2          = s.rs2;
    ex_valid        = s.ex_valid;
    ex_is_load      = s.ex_is_load;
    ex_gprs_waddr   = s.waddr;
    ex_redirect     = s.redirect;
    ex_muldiv_start = s.md_start;
    ex_muldiv_done  = s.md_done;
    mem_req         = s.mem_req;
    mem_ready       = s.mem_ready;
    trap_req        = s.trap_req;
  endtask

  function automatic stim_t idle();
    stim_t s = '0;
    s.mem_ready = 1;
    return s;
  endfunction

  function automatic stim_t load_use_stim();
    stim_t s = idle();
    s.ex_valid = 1; s.ex_is_load = 1; s.waddr = 5;
    s.id_valid = 1; s.rs1_used = 1; s.rs1 = 5; s.rs2_used = 1; s.rs2 = 1;
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.id_valid   = ($urandom_range(0, 3) != 0);
    s.rs1_used   = ($urandom_range(0, 1) == 1);
    s.rs2_used   = ($urandom_range(0, 1) == 1);
    s.rs1        = 5'($urandom_range(0, 3));
    s.rs2        = 5'($urandom_range(0, 3));
    s.ex_valid   = ($urandom_range(0, 4) != 0);
    s.ex_is_load = ($urandom_range(0, 1) == 1);
    s.waddr      = 5'($urandom_range(0, 3));
    s.redirect   = ($urandom_range(0, 5) == 0);
    s.md_start   = ($urandom_range(0, 7) == 0);
    s.md_done    = ($urandom_range(0, 2) == 0);
    s.mem_req    = ($urandom_range(0, 3) == 0);
    s.mem_ready  = ($urandom_range(0, 1) == 1);
    s.trap_req   = ($urandom_range(0, 24) == 0);
    return s;
  endfunction

  task automatic reset_cycle();
    @(posedge clk); #1;
    rst = 1'b0;
    drive(idle());
    model_reset();
    q.push_back(reset_exp());
  endtask

  // One clock of stimulus; drop_mid pulls reset low between edges.
  task automatic step(input stim_t s, input bit drop_mid = 1'b0);
    exp_t e;
    @(posedge clk); #1;
    rst = 1'b1;
    drive(s);
    if (drop_mid) begin
      model_reset();
      q.push_back(reset_exp());
      #2 rst = 1'b0;
    end else begin
      model_step(s, e);
      q.push_back(e);
    end
  endtask

  initial begin
    stim_t s;
    rst = 1'b0;
    drive(idle());
    reset_cycle();
    reset_cycle();

    // Load-use, then the x0 and unused-source cases.
    step(load_use_stim());
    step(idle());
    s = load_use_stim(); s.waddr = 0; s.rs1 = 0; step(s);
    s = load_use_stim(); s.rs1_used = 0; step(s);

    // Redirect together with a load-use match.
    s = load_use_stim(); s.redirect = 1; step(s);

    // Mul/div with done four cycles after start, then start+done together.
    s = idle(); s.ex_valid = 1; s.md_start = 1; step(s);
    s = idle(); s.ex_valid = 1;
    repeat (3) step(s);
    s.md_done = 1; step(s);
    s = idle(); s.ex_valid = 1; s.md_start = 1; s.md_done = 1; step(s);

    // Memory wait with a redirect held in EX.
    s = idle(); s.mem_req = 1; s.mem_ready = 0; s.redirect = 1;
    repeat (3) step(s);
    s.mem_ready = 1; step(s);
    step(idle());

    // Trap while a mul/div is in flight.
    s = idle(); s.ex_valid = 1; s.md_start = 1; step(s);
    s = idle(); s.ex_valid = 1; step(s);
    s.trap_req = 1; step(s);
    step(s);
    step(idle());
    step(idle());

    for (int i = 0; i < 600; i++) step(rand_stim());

    // Async reset in the middle of a drain.
    s = idle(); s.trap_req = 1; step(s);
    step(idle());
    step(idle(), 1'b1);
    reset_cycle();

    // Continued stalls drive the counter into saturation and hold it there.
    for (int i = 0; i < CNT_MAX + 6; i++) step(load_use_stim());
    step(idle());

    repeat (2) @(negedge clk);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
